// File: rtl/net_delay_line.sv
// Delays s = a & b by DELAY cycles onto a registered output, either as a pure
// transport delay (shift register) or as an inertial delay that swallows short pulses.

module net_delay_line #(
  parameter int unsigned DELAY    = 10,
  parameter int unsigned INERTIAL = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             w,
  output logic             w_valid,
  output logic             rej_pulse,
  output logic [CNT_W-1:0] rej_cnt
);

  localparam int unsigned PW = $clog2(DELAY + 2);
  localparam int unsigned CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  typedef enum logic {StStable, StPending} state_e;

  logic s;
  assign s = a & b;

  // Priming: w_valid rises one edge after DELAY sampling edges have elapsed.
  logic [PW-1:0] prime_q;
  logic          w_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_q   <= '0;
      w_valid_q <= 1'b0;
    end else begin
      if (prime_q != PW'(DELAY)) prime_q <= prime_q + PW'(1);
      w_valid_q <= w_valid_q | (prime_q == PW'(DELAY));
    end
  end

  assign w_valid = w_valid_q;

  if (INERTIAL == 0) begin : g_transport
    logic [DELAY-1:0] sh_q;

    if (DELAY == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= s;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= {sh_q[DELAY-2:0], s};
      end
    end

    assign w         = sh_q[DELAY-1];
    assign rej_pulse = 1'b0;
    assign rej_cnt   = '0;
  end else begin : g_inertial
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             w_q, w_d;
    logic             rej_q, rej_d;
    logic [CNT_W-1:0] rc_q, rc_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      rej_d   = 1'b0;
      rc_d    = rc_q;
      if (s != w_q) begin
        if (cnt_q == CW'(DELAY - 1)) begin
          w_d     = s;
          cnt_d   = '0;
          state_d = StStable;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = StPending;
        end
      end else if (state_q == StPending) begin
        // Input returned to w before the pulse matured: drop it and count it.
        cnt_d   = '0;
        state_d = StStable;
        rej_d   = 1'b1;
        if (rc_q != {CNT_W{1'b1}}) rc_d = rc_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= StStable;
        cnt_q   <= '0;
        w_q     <= 1'b0;
        rej_q   <= 1'b0;
        rc_q    <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        w_q     <= w_d;
        rej_q   <= rej_d;
        rc_q    <= rc_d;
      end
    end

    assign w         = w_q;
    assign rej_pulse = rej_q;
    assign rej_cnt   = rc_q;
  end

endmodule

// File: tb/tb_net_delay_line.sv
// Bench for net_delay_line: three configurations share one stimulus stream; directed
// vector table plus randomized run-length stimulus against a sample-history model.

module tb_net_delay_line;

  localparam int TR = 0;  // DELAY=10, transport
  localparam int IN = 1;  // DELAY=10, inertial, CNT_W=2
  localparam int D1 = 2;  // DELAY=1, inertial

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, a = 1'b0, b = 1'b0;
  logic w_tr, v_tr, rp_tr;
  logic [7:0] rc_tr;
  logic w_in, v_in, rp_in;
  logic [1:0] rc_in;
  logic w_d1, v_d1, rp_d1;
  logic [7:0] rc_d1;

  net_delay_line #(.DELAY(10), .INERTIAL(0), .CNT_W(8)) u_tr (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .w(w_tr), .w_valid(v_tr), .rej_pulse(rp_tr), .rej_cnt(rc_tr)
  );
  net_delay_line #(.DELAY(10), .INERTIAL(1), .CNT_W(2)) u_in (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .w(w_in), .w_valid(v_in), .rej_pulse(rp_in), .rej_cnt(rc_in)
  );
  net_delay_line #(.DELAY(1), .INERTIAL(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .w(w_d1), .w_valid(v_d1), .rej_pulse(rp_d1), .rej_cnt(rc_d1)
  );

  typedef struct {
    bit rst_n; bit a; bit b;
    int sel; bit chk;
    bit w; bit valid; bit rp; int rc;
  } vec_t;

  vec_t tbl[$];
  int errors = 0;
  int checks = 0;

  // Reference model: history of samples since reset.
  bit hist[$];
  int n_edges;
  bit m_w_in, m_w_d1, m_rp_in, m_rp_d1;
  int m_rc_in, m_rc_d1;

  function automatic bit last_all(int d, bit v);
    if (hist.size() < d) return 1'b0;
    for (int i = 0; i < d; i++) if (hist[hist.size() - 1 - i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(bit r, bit aa, bit bb);
    bit s, have_prev, prev;
    if (!r) begin
      hist.delete();
      n_edges = 0;
      m_w_in = 0; m_w_d1 = 0; m_rp_in = 0; m_rp_d1 = 0;
      m_rc_in = 0; m_rc_d1 = 0;
    end else begin
      s = aa & bb;
      have_prev = hist.size() > 0;
      prev = have_prev ? hist[hist.size() - 1] : 1'b0;
      // A pulse is rejected when s returns to w while the previous sample still differed.
      m_rp_in = have_prev && (s == m_w_in) && (prev != m_w_in);
      m_rp_d1 = have_prev && (s == m_w_d1) && (prev != m_w_d1);
      if (m_rp_in) m_rc_in++;
      if (m_rp_d1) m_rc_d1++;
      hist.push_back(s);
      if (hist.size() > 70) void'(hist.pop_front());
      if (last_all(10, !m_w_in)) m_w_in = !m_w_in;
      if (last_all(1, !m_w_d1)) m_w_d1 = !m_w_d1;
      if (n_edges < 1000) n_edges++;
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit e_w_tr;
    e_w_tr = (n_edges >= 10) ? hist[hist.size() - 10] : 1'b0;
    chk("tr.w", 32'(w_tr), 32'(e_w_tr));
    chk("tr.w_valid", 32'(v_tr), 32'(n_edges >= 11));
    chk("tr.rej_pulse", 32'(rp_tr), 0);
    chk("tr.rej_cnt", 32'(rc_tr), 0);
    chk("in.w", 32'(w_in), 32'(m_w_in));
    chk("in.w_valid", 32'(v_in), 32'(n_edges >= 11));
    chk("in.rej_pulse", 32'(rp_in), 32'(m_rp_in));
    chk("in.rej_cnt", 32'(rc_in), (m_rc_in > 3) ? 3 : m_rc_in);
    chk("d1.w", 32'(w_d1), 32'(m_w_d1));
    chk("d1.w_valid", 32'(v_d1), 32'(n_edges >= 2));
    chk("d1.rej_pulse", 32'(rp_d1), 32'(m_rp_d1));
    chk("d1.rej_cnt", 32'(rc_d1), (m_rc_d1 > 255) ? 255 : m_rc_d1);
  endtask

  task automatic step(bit r, bit aa, bit bb);
    rst_n = r; a = aa; b = bb;
    @(posedge clk);
    model_step(r, aa, bb);
    #1;
    check_model();
  endtask

  task automatic add(bit r, bit aa, bit bb, int sel, bit w, bit v, bit rp, int rc);
    vec_t t;
    t.rst_n = r; t.a = aa; t.b = bb; t.sel = sel; t.chk = 1'b1;
    t.w = w; t.valid = v; t.rp = rp; t.rc = rc;
    tbl.push_back(t);
  endtask

  task automatic check_row(int i, vec_t t);
    logic aw, av, ar;
    logic [31:0] ac;
    unique case (t.sel)
      TR: begin aw = w_tr; av = v_tr; ar = rp_tr; ac = 32'(rc_tr); end
      IN: begin aw = w_in; av = v_in; ar = rp_in; ac = 32'(rc_in); end
      default: begin aw = w_d1; av = v_d1; ar = rp_d1; ac = 32'(rc_d1); end
    endcase
    chk($sformatf("vec[%0d].w", i), 32'(aw), 32'(t.w));
    chk($sformatf("vec[%0d].w_valid", i), 32'(av), 32'(t.valid));
    chk($sformatf("vec[%0d].rej_pulse", i), 32'(ar), 32'(t.rp));
    chk($sformatf("vec[%0d].rej_cnt", i), ac, 32'(t.rc));
  endtask

  initial begin
    int cnt;
    bit s;
    // Transport: steady a=b=1 from edge 0; reset row also has a=b=1 (reset wins).
    add(0, 1, 1, TR, 0, 0, 0, 0);
    for (int e = 0; e < 12; e++) add(1, 1, 1, TR, e >= 9, e >= 10, 0, 0);
    // Transport: 3-cycle pulse at edges 20..22 reappears after edges 29..31.
    add(0, 1, 1, TR, 0, 0, 0, 0);
    for (int e = 0; e < 35; e++) begin
      s = (e >= 20 && e <= 22);
      add(1, s, 1, TR, e >= 29 && e <= 31, e >= 10, 0, 0);
    end
    // Inertial: 9-cycle pulse rejected, 10-cycle pulse passes for 10 cycles.
    add(0, 1, 1, IN, 0, 0, 0, 0);
    for (int e = 0; e < 46; e++) begin
      s = (e >= 5 && e <= 13) || (e >= 20 && e <= 29);
      add(1, 1, s, IN, e >= 29 && e <= 38, e >= 10, e == 14, (e >= 14) ? 1 : 0);
    end
    // Inertial CNT_W=2: five 2-cycle pulses, strobes every third edge, count sticks at 3.
    add(0, 1, 1, IN, 0, 0, 0, 0);
    for (int e = 0; e < 18; e++) begin
      s = (e % 3 != 2) && (e < 15);
      cnt = (e + 1) / 3;
      if (cnt > 5) cnt = 5;
      add(1, s, s, IN, 0, e >= 10, (e % 3 == 2) && (e <= 14), (cnt > 3) ? 3 : cnt);
    end
    // Inertial: reset while pending at cnt=5 discards the transition uncounted.
    add(0, 1, 1, IN, 0, 0, 0, 0);
    for (int e = 0; e < 5; e++) add(1, 1, 1, IN, 0, 0, 0, 0);
    add(0, 1, 1, IN, 0, 0, 0, 0);
    for (int e = 0; e < 12; e++) add(1, 0, 1, IN, 0, e >= 10, 0, 0);
    // DELAY=1 inertial: toggling input tracks one edge later, never rejected.
    add(0, 1, 1, D1, 0, 0, 0, 0);
    for (int e = 0; e < 12; e++) begin
      s = (e % 2 == 0);
      add(1, s, 1, D1, s, e >= 1, 0, 0);
    end

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst_n, tbl[i].a, tbl[i].b);
      if (tbl[i].chk) check_row(i, tbl[i]);
    end

    // Randomized run-length stimulus with occasional resets.
    for (int seg = 0; seg < 160; seg++) begin
      int len;
      bit lvl, ra, rb;
      len = int'($urandom_range(1, 24));
      lvl = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) step(0, 1'($urandom), 1'($urandom));
      for (int k = 0; k < len; k++) begin
        if (lvl) begin
          ra = 1; rb = 1;
        end else begin
          ra = 1'($urandom);
          rb = ra ? 1'b0 : 1'($urandom);
        end
        step(1, ra, rb);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
